seq_arb_4in_requester: RTL and testbench
========================================

SEQ_ARB_4IN_REQUESTER -- requirements
Module: seq_arb_4in_requester

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock, rising-edge.
REQ-002 The block SHALL have these ports: reset, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: in_val, input, 4, per-client transaction submit.
REQ-004 The block SHALL have these ports: in_rdy, output, 4, per-client submit accept.
REQ-005 The block SHALL have these ports: reqs, output, 4, requests driven to the 4-input weighted arbiter.
REQ-006 The block SHALL have these ports: grants, input, 4, one-hot grant returned by the arbiter.
REQ-007 The block SHALL have these ports: preset, output, 1, weight-reload command to the arbiter.
REQ-008 The block SHALL have these ports: done, output, 4, per-client completion pulse.
REQ-009 The block SHALL have these ports: err, output, 1, sticky protocol-error flag.
REQ-010 The block SHALL use parameters: none; weights are fixed at 3,3,1,1 for clients 0..3.

Function
REQ-011 The block SHALL keep per-client pending[i], 3 bits, range 0..7, counting accepted but ungranted transactions.
REQ-012 The block SHALL drive in_rdy[i] = (pending[i] != 7), combinationally from state only.
REQ-013 The block SHALL count a submit as accepted in a cycle where in_val[i] && in_rdy[i].
REQ-014 The block SHALL keep per-client credit[i], 3 bits, mirroring the arbiter's weight counters.
REQ-015 The block SHALL drive reqs[i] = (pending[i] != 0) && (credit[i] != 0) && !preset, combinationally from registered state only, with no path from grants or in_val.
REQ-016 The block SHALL honour a grant only when grants is exactly one-hot with bit i set and reqs[i] is 1 in the same cycle.
REQ-017 On an honoured grant to client i, the block SHALL, at the next edge, decrement pending[i] by 1, decrement credit[i] by 1, and set done[i] for exactly one cycle.
REQ-018 When a submit is accepted and a grant is honoured for the same client in the same cycle, the block SHALL leave pending[i] unchanged, still decrement credit[i], and still pulse done[i].
REQ-019 The block SHALL ignore any grants value that is non-one-hot and non-zero, or that targets a client with reqs[i]=0; it SHALL change no counter, and SHALL set err=1 at the next edge.
REQ-020 Once set, err SHALL remain 1 until reset.
REQ-021 The block SHALL drive preset combinationally as (pending != all-zero) && for every i, (pending[i]==0 || credit[i]==0).
REQ-022 At an edge where preset=1, the block SHALL reload credit to {3,3,1,1}.
REQ-023 The block SHALL deassert preset in the cycle after the credit reload.
REQ-024 With all pending zero, the block SHALL hold preset at 0 and SHALL NOT change credit.
REQ-025 The block SHALL saturate no counter arithmetic: pending never exceeds 7 because in_rdy gates it, and credit never underflows because reqs gates it.
REQ-026 done SHALL be a registered output; all other outputs SHALL be combinational from registered state.

Reset
REQ-027 While reset=1, the block SHALL set pending to 0 for all clients, credit to {3,3,1,1}, done to 0, and err to 0.
REQ-028 During reset, the resulting outputs SHALL be reqs=0, preset=0, and in_rdy=4'b1111 from the first cycle after reset.
REQ-029 A reset asserted mid-operation SHALL discard all pending transactions and SHALL produce no done pulse at the next edge.

Verification
REQ-030 The bench SHALL cover this scenario: reset, then in_val=0001 for 1 cycle -> next cycle reqs=0001; drive grants=0001 -> following cycle done=0001 and reqs=0000.
REQ-031 The bench SHALL cover this scenario: submit client 2 twice, granting each time reqs[2]=1 -> after the first grant credit[2]=0, pending[2]=1, reqs=0000, preset=1 for one cycle -> then reqs=0100 again.
REQ-032 The bench SHALL cover this scenario: hold in_val=1000 for 8 cycles with no grants -> in_rdy[3] deasserts after 7 accepts; pending[3]=7, so the 8th submit is not accepted.
REQ-033 The bench SHALL cover this scenario: client 1 has pending 2 and receives in_val[1]=1 and grants=0010 in the same cycle -> pending stays 2, credit[1] 3->2, done=0010.
REQ-034 The bench SHALL cover this scenario: drive grants=0110, or grants=0100 while reqs[2]=0 -> counters unchanged and err=1 next cycle, held until reset.
REQ-035 The bench SHALL cover this scenario: reset asserted while pending={1,2,0,3} -> next cycle reqs=0000, done=0000, in_rdy=1111, credit={3,3,1,1}.

Source files
------------

// File: rtl/seq_arb_4in_requester.sv
// Request front-end for a 4-input weighted arbiter (weights 3,3,1,1).
// Tracks per-client pending transactions, mirrors the arbiter's weight
// counters, issues the weight-reload (preset) command and flags bad grants.
module seq_arb_4in_requester (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_val,
    output logic [3:0] in_rdy,
    output logic [3:0] reqs,
    input  logic [3:0] grants,
    output logic       preset,
    output logic [3:0] done,
    output logic       err
);

    logic [2:0] pending [4];
    logic [2:0] credit  [4];

    logic [3:0] has_pend;
    logic [3:0] stalled;
    logic [3:0] accept;
    logic [3:0] honour;
    logic       grant_onehot;
    logic       bad_grant;

    // Reload value of each client's weight counter.
    function automatic logic [2:0] weight(input int idx);
        return (idx < 2) ? 3'd3 : 3'd1;
    endfunction

    // Outputs derived from registered state only; no path from in_val/grants.
    always_comb begin
        has_pend = '0;
        stalled  = '0;
        in_rdy   = '0;
        for (int i = 0; i < 4; i++) begin
            has_pend[i] = (pending[i] != 3'd0);
            stalled[i]  = (pending[i] == 3'd0) || (credit[i] == 3'd0);
            in_rdy[i]   = (pending[i] != 3'd7);
        end
        // Reload once every client with work left has exhausted its credit.
        preset = (has_pend != 4'd0) && (stalled == 4'hF);
        reqs   = '0;
        for (int i = 0; i < 4; i++) begin
            reqs[i] = has_pend[i] && (credit[i] != 3'd0) && !preset;
        end
    end

    // Grant qualification and submit acceptance for the current cycle.
    always_comb begin
        grant_onehot = (grants != 4'd0) && ((grants & (grants - 4'd1)) == 4'd0);
        honour       = grant_onehot ? (grants & reqs) : 4'd0;
        bad_grant    = (grants != 4'd0) && (honour == 4'd0);
        accept       = in_val & in_rdy;
    end

    // Counter, completion pulse and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pending[i] <= 3'd0;
                credit[i]  <= weight(i);
            end
            done <= 4'd0;
            err  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({accept[i], honour[i]})
                    2'b10:   pending[i] <= pending[i] + 3'd1;
                    2'b01:   pending[i] <= pending[i] - 3'd1;
                    default: pending[i] <= pending[i];
                endcase
                // preset forces reqs low, so it never coincides with a grant.
                if (preset) begin
                    credit[i] <= weight(i);
                end else if (honour[i]) begin
                    credit[i] <= credit[i] - 3'd1;
                end
            end
            done <= honour;
            err  <= err | bad_grant;
        end
    end

endmodule

// File: tb/tb_seq_arb_4in_requester.sv
// Scoreboard bench for seq_arb_4in_requester: a behavioural model predicts
// the post-edge outputs, which are queued at drive time and compared after
// the edge, plus directed checks for the key scenarios.
module tb_seq_arb_4in_requester;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_val;
    logic [3:0] in_rdy;
    logic [3:0] reqs;
    logic [3:0] grants;
    logic       preset;
    logic [3:0] done;
    logic       err;

    seq_arb_4in_requester dut (
        .clk    (clk),
        .reset  (reset),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .reqs   (reqs),
        .grants (grants),
        .preset (preset),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] done;
        logic [3:0] reqs;
        logic [3:0] in_rdy;
        logic       preset;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int   pend [4];
    int   cred [4];
    logic [3:0] m_done;
    logic       m_err;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
        end
    endtask

    function automatic int wt(input int idx);
        return (idx < 2) ? 3 : 1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit any_pend = 0;
        bit all_stuck = 1;
        for (int i = 0; i < 4; i++) begin
            if (pend[i] > 0) any_pend = 1;
            if (pend[i] > 0 && cred[i] > 0) all_stuck = 0;
        end
        e.preset = any_pend && all_stuck;
        for (int i = 0; i < 4; i++) begin
            e.reqs[i]   = (pend[i] > 0) && (cred[i] > 0) && !e.preset;
            e.in_rdy[i] = (pend[i] < 7);
        end
        e.done = m_done;
        e.err  = m_err;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0;
            cred[i] = wt(i);
        end
        m_done = 4'd0;
        m_err  = 1'b0;
    endtask

    task automatic model_update(input logic r, input logic [3:0] v, input logic [3:0] g);
        exp_t cur;
        int   nset;
        int   tgt;
        bit   ok;
        if (r) begin
            model_reset();
            return;
        end
        cur  = model_out();
        nset = 0;
        tgt  = -1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                nset++;
                tgt = i;
            end
        end
        ok = (nset == 1) && cur.reqs[tgt];
        m_done = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && pend[i] < 7) pend[i] = pend[i] + 1;
            if (ok && tgt == i) begin
                pend[i]   = pend[i] - 1;
                cred[i]   = cred[i] - 1;
                m_done[i] = 1'b1;
            end
            if (cur.preset) cred[i] = wt(i);
        end
        if (nset != 0 && !ok) m_err = 1'b1;
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] g);
        exp_t cur;
        exp_t got;
        reset  = r;
        in_val = v;
        grants = g;
        #1;
        cur = model_out();
        chk("comb_reqs", {4'd0, reqs}, {4'd0, cur.reqs});
        chk("comb_in_rdy", {4'd0, in_rdy}, {4'd0, cur.in_rdy});
        chk("comb_preset", {7'd0, preset}, {7'd0, cur.preset});
        model_update(r, v, g);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("done", {4'd0, done}, {4'd0, got.done});
        chk("reqs", {4'd0, reqs}, {4'd0, got.reqs});
        chk("in_rdy", {4'd0, in_rdy}, {4'd0, got.in_rdy});
        chk("preset", {7'd0, preset}, {7'd0, got.preset});
        chk("err", {7'd0, err}, {7'd0, got.err});
    endtask

    // Grant whatever the model says is requesting until nothing is pending.
    task automatic drain();
        exp_t e;
        logic [3:0] r;
        bit   empty;
        for (int n = 0; n < 60; n++) begin
            empty = 1;
            for (int i = 0; i < 4; i++) if (pend[i] > 0) empty = 0;
            if (empty) return;
            e = model_out();
            r = e.reqs;
            step(1'b0, 4'd0, r & (~r + 4'd1));
        end
        chk("drain_timeout", 8'd1, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        logic [3:0] r;
        logic [3:0] g;
        exp_t e;

        reset  = 1'b1;
        in_val = 4'd0;
        grants = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reqs", {4'd0, reqs}, 8'h00);
        chk("rst_in_rdy", {4'd0, in_rdy}, 8'h0F);
        chk("rst_preset", {7'd0, preset}, 8'h00);
        chk("rst_done", {4'd0, done}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);

        // single submit and grant on client 0
        step(1'b1, 4'd0, 4'd0);
        step(1'b0, 4'b0001, 4'd0);
        chk("s1_reqs", {4'd0, reqs}, 8'h01);
        step(1'b0, 4'd0, 4'b0001);
        chk("s1_done", {4'd0, done}, 8'h01);
        chk("s1_reqs_after", {4'd0, reqs}, 8'h00);
        step(1'b0, 4'd0, 4'd0);
        chk("s1_done_pulse", {4'd0, done}, 8'h00);

        // client 2 credit exhaustion and reload
        step(1'b0, 4'b0100, 4'd0);
        step(1'b0, 4'b0100, 4'd0);
        chk("s2_reqs", {4'd0, reqs}, 8'h04);
        step(1'b0, 4'd0, 4'b0100);
        chk("s2_done", {4'd0, done}, 8'h04);
        chk("s2_reqs_zero", {4'd0, reqs}, 8'h00);
        chk("s2_preset", {7'd0, preset}, 8'h01);
        step(1'b0, 4'd0, 4'd0);
        chk("s2_preset_drop", {7'd0, preset}, 8'h00);
        chk("s2_reqs_again", {4'd0, reqs}, 8'h04);
        step(1'b0, 4'd0, 4'b0100);
        step(1'b0, 4'd0, 4'd0);
        chk("s2_idle_preset", {7'd0, preset}, 8'h00);

        // client 3 fills to 7 pending
        for (int k = 0; k < 8; k++) step(1'b0, 4'b1000, 4'd0);
        chk("s3_in_rdy", {4'd0, in_rdy}, 8'h07);
        chk("s3_reqs", {4'd0, reqs}, 8'h08);
        drain();

        // simultaneous submit and grant on client 1
        step(1'b1, 4'd0, 4'd0);
        step(1'b0, 4'b0010, 4'd0);
        step(1'b0, 4'b0010, 4'd0);
        step(1'b0, 4'b0010, 4'b0010);
        chk("s4_done", {4'd0, done}, 8'h02);
        step(1'b0, 4'b0010, 4'd0);
        step(1'b0, 4'd0, 4'b0010);
        step(1'b0, 4'd0, 4'b0010);
        chk("s4_preset", {7'd0, preset}, 8'h01);
        drain();

        // illegal grants
        step(1'b1, 4'd0, 4'd0);
        step(1'b0, 4'b0011, 4'd0);
        chk("s5_err_clear", {7'd0, err}, 8'h00);
        step(1'b0, 4'd0, 4'b0110);
        chk("s5_err_set", {7'd0, err}, 8'h01);
        chk("s5_no_done", {4'd0, done}, 8'h00);
        chk("s5_reqs_kept", {4'd0, reqs}, 8'h03);
        step(1'b0, 4'd0, 4'b0100);
        step(1'b0, 4'd0, 4'b0011);
        step(1'b0, 4'd0, 4'b0001);
        chk("s5_legal_done", {4'd0, done}, 8'h01);
        step(1'b0, 4'd0, 4'd0);
        chk("s5_err_sticky", {7'd0, err}, 8'h01);
        step(1'b1, 4'd0, 4'd0);
        chk("s5_err_reset", {7'd0, err}, 8'h00);

        // reset mid-operation with pending {1,2,0,3}
        step(1'b0, 4'b1011, 4'd0);
        step(1'b0, 4'b1010, 4'd0);
        step(1'b0, 4'b1000, 4'd0);
        step(1'b1, 4'b1111, 4'b0001);
        chk("s6_reqs", {4'd0, reqs}, 8'h00);
        chk("s6_done", {4'd0, done}, 8'h00);
        chk("s6_in_rdy", {4'd0, in_rdy}, 8'h0F);
        step(1'b0, 4'd0, 4'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 4'b0001, 4'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 4'b0001);
        chk("s6_credit0_reload", {7'd0, preset}, 8'h01);
        drain();

        // random legal traffic
        for (int k = 0; k < 300; k++) begin
            v = 4'($urandom_range(0, 15));
            e = model_out();
            r = e.reqs;
            g = 4'd0;
            if ($urandom_range(0, 3) != 0 && r != 4'd0) begin
                for (int t = 0; t < 16; t++) begin
                    int c = $urandom_range(0, 3);
                    if (r[c]) begin
                        g = 4'd1 << c;
                        break;
                    end
                end
                if (g == 4'd0) g = r & (~r + 4'd1);
            end
            step(1'b0, v, g);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
